// File: rtl/ad9361_tdd_pkg.sv
// ad9361_tdd_pkg: shared state encoding and default widths for the AD9361 TDD controller
package ad9361_tdd_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUNNING} tdd_state_t;
  localparam int CNT_W_DEF = 24;
  localparam int BURST_W_DEF = 16;
endpackage

// File: rtl/ad9361_tdd_window.sv
// ad9361_tdd_window: [on, off) compare on the frame counter with a registered gate output
module ad9361_tdd_window #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         active,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] on,
  input  logic [W-1:0] off,
  output logic         hit,
  output logic         win
);
  // on >= off can never satisfy both bounds, so empty windows fall out naturally
  assign hit = active && (on <= cnt) && (cnt < off);
  always_ff @(posedge clk)
    win <= rst ? 1'b0 : hit;
endmodule

// File: rtl/ad9361_tdd_ctrl.sv
// ad9361_tdd_ctrl: TDD frame scheduler for AD9361 ENSM pin control and datapath gating.
// Define AD9361_TDD_SYNC_OUT_EN to add sync_out, a pulse on the first frame_start of each run.
module ad9361_tdd_ctrl
  import ad9361_tdd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_enable,
  input  logic               ctrl_sync_en,
  input  logic               sync_in,
  input  logic [CNT_W-1:0]   frame_length,
  input  logic [CNT_W-1:0]   rx_on,
  input  logic [CNT_W-1:0]   rx_off,
  input  logic [CNT_W-1:0]   tx_on,
  input  logic [CNT_W-1:0]   tx_off,
  input  logic [BURST_W-1:0] burst_count,
  output logic               enable,
  output logic               txnrx,
  output logic               rx_window,
  output logic               tx_window,
  output logic               frame_start,
`ifdef AD9361_TDD_SYNC_OUT_EN
  output logic               sync_out,
`endif
  output logic               busy,
  output logic               cfg_error
);
  tdd_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, fl_q, rx_on_q, rx_off_q, tx_on_q, tx_off_q;
  logic [BURST_W-1:0] burst_q, frames_done;
  logic tx_sup, running, wrap, stop, latch, rx_hit, tx_hit, ovl, range_err;
  assign running = state == RUNNING;
  assign wrap = cnt == fl_q;
  assign stop = !ctrl_enable || (burst_q != '0 && (frames_done + 1'b1) == burst_q);
  assign latch = state == IDLE && ctrl_enable;
  assign ovl = rx_on < rx_off && tx_on < tx_off && rx_on < tx_off && tx_on < rx_off;
  assign range_err = {1'b0, rx_off} > {1'b0, frame_length} + 1'b1 ||
                     {1'b0, tx_off} > {1'b0, frame_length} + 1'b1;
  assign busy = state != IDLE;
  assign enable = rx_window | tx_window;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = !ctrl_enable ? IDLE : ctrl_sync_en ? ARMED : RUNNING;
      ARMED:   state_nx = !ctrl_enable ? IDLE : sync_in ? RUNNING : ARMED;
      RUNNING: state_nx = wrap && stop ? IDLE : RUNNING;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      frames_done <= '0;
      cfg_error <= 1'b0;
      tx_sup <= 1'b0;
      fl_q <= '0;
      rx_on_q <= '0;
      rx_off_q <= '0;
      tx_on_q <= '0;
      tx_off_q <= '0;
      burst_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= (!running || wrap) ? '0 : cnt + 1'b1;
      frames_done <= !running ? '0 : wrap ? frames_done + 1'b1 : frames_done;
      if (latch) begin
        fl_q <= frame_length;
        rx_on_q <= rx_on;
        rx_off_q <= rx_off;
        tx_on_q <= tx_on;
        tx_off_q <= tx_off;
        burst_q <= burst_count;
        cfg_error <= range_err | ovl;
        tx_sup <= ovl;
      end
    end
  end
  ad9361_tdd_window #(.W(CNT_W)) u_rx (
    .clk(clk), .rst(rst), .active(running), .cnt(cnt),
    .on(rx_on_q), .off(rx_off_q), .hit(rx_hit), .win(rx_window)
  );
  // overlapping windows: RX keeps the radio, TX stays shut for the whole run
  ad9361_tdd_window #(.W(CNT_W)) u_tx (
    .clk(clk), .rst(rst), .active(running && !tx_sup), .cnt(cnt),
    .on(tx_on_q), .off(tx_off_q), .hit(tx_hit), .win(tx_window)
  );
  always_ff @(posedge clk) begin
    frame_start <= !rst && running && cnt == '0;
    txnrx <= rst ? 1'b0 : tx_hit ? 1'b1 : rx_hit ? 1'b0 : txnrx;
  end
`ifdef AD9361_TDD_SYNC_OUT_EN
  always_ff @(posedge clk)
    sync_out <= !rst && running && cnt == '0 && frames_done == '0;
`endif
endmodule

// File: tb/tb_ad9361_tdd_ctrl.sv
// tb_ad9361_tdd_ctrl: scoreboard bench; expected output events are queued by stimulus, matched by a monitor
module tb_ad9361_tdd_ctrl;
  logic clk = 0, rst = 1, ctrl_enable = 0, ctrl_sync_en = 0, sync_in = 0;
  logic [23:0] frame_length = 0, rx_on = 0, rx_off = 0, tx_on = 0, tx_off = 0;
  logic [15:0] burst_count = 0;
  logic enable, txnrx, rx_window, tx_window, frame_start, busy, cfg_error;
`ifdef AD9361_TDD_SYNC_OUT_EN
  logic sync_out;
`else
  logic sync_out = 0;
`endif
  int cyc = 0, total = 0, passed = 0;
  typedef struct {string k; int c;} ev_t;
  ev_t exp_q[$];

  ad9361_tdd_ctrl dut (
    .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .ctrl_sync_en(ctrl_sync_en),
    .sync_in(sync_in), .frame_length(frame_length), .rx_on(rx_on), .rx_off(rx_off),
    .tx_on(tx_on), .tx_off(tx_off), .burst_count(burst_count), .enable(enable),
    .txnrx(txnrx), .rx_window(rx_window), .tx_window(tx_window),
    .frame_start(frame_start),
`ifdef AD9361_TDD_SYNC_OUT_EN
    .sync_out(sync_out),
`endif
    .busy(busy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int rank(input string k);
    return k == "fs" ? 0 : k == "rxr" ? 1 : k == "rxf" ? 2 : k == "txr" ? 3 : k == "txf" ? 4 : 5;
  endfunction

  task automatic push(input string k, input int c);
    ev_t e;
    int i = 0;
    e.k = k;
    e.c = c;
    while (i < exp_q.size() && (exp_q[i].c < c || (exp_q[i].c == c && rank(exp_q[i].k) <= rank(k)))) i++;
    exp_q.insert(i, e);
  endtask

  task automatic push_so(input int c);
`ifdef AD9361_TDD_SYNC_OUT_EN
    push("so", c);
`else
    if (c < 0) push("so", c);
`endif
  endtask

  // monitor: every observed output event must match the head of the queue
  task automatic chk_ev(input string k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL ev_%s: unexpected event at cycle %0d", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.k == k && e.c == cyc) passed++;
    else $display("FAIL ev_%s: got %s@%0d expected %s@%0d", k, k, cyc, e.k, e.c);
  endtask

  logic rx_p = 0, tx_p = 0, en_p = 0, tn_p = 0;
  always @(negedge clk) begin
    if (frame_start) chk_ev("fs");
    if (rx_window && !rx_p) chk_ev("rxr");
    if (!rx_window && rx_p) chk_ev("rxf");
    if (tx_window && !tx_p) chk_ev("txr");
    if (!tx_window && tx_p) chk_ev("txf");
    if (sync_out) chk_ev("so");
    if (enable || rx_window || tx_window) begin
      total++;
      if (enable == (rx_window | tx_window) && !(tx_window && !txnrx) && !(rx_window && txnrx) &&
          !(en_p && txnrx != tn_p))
        passed++;
      else
        $display("FAIL pins: enable=%0b txnrx=%0b prev_txnrx=%0b rx=%0b tx=%0b at cycle %0d",
                 enable, txnrx, tn_p, rx_window, tx_window, cyc);
    end
    rx_p = rx_window;
    tx_p = tx_window;
    en_p = enable;
    tn_p = txnrx;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg(input int fl, input int ron, input int roff, input int ton, input int toff,
                     input int bc, input logic se);
    frame_length = fl[23:0];
    rx_on = ron[23:0];
    rx_off = roff[23:0];
    tx_on = ton[23:0];
    tx_off = toff[23:0];
    burst_count = bc[15:0];
    ctrl_sync_en = se;
  endtask

  task automatic drain(input int c);
    wait_cyc(c);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic int outs();
    return {enable, txnrx, rx_window, tx_window, frame_start, busy, cfg_error, sync_out};
  endfunction

  initial begin
    int l, s;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 0;
    @(negedge clk);
    check("idle_outputs", outs(), 0);

    // two frames, stop requested at counter 20 of frame 2
    cfg(99, 0, 40, 50, 90, 0, 0);
    l = cyc + 1;
    for (int f = 0; f < 2; f++) begin
      push("fs", l + 100 * f + 1);
      push("rxr", l + 100 * f + 1);
      push("rxf", l + 100 * f + 41);
      push("txr", l + 100 * f + 51);
      push("txf", l + 100 * f + 91);
    end
    push_so(l + 1);
    ctrl_enable = 1;
    @(negedge clk);
    check("t1_busy_at_start", busy, 1);
    check("t1_no_cfg_error", cfg_error, 0);
    wait_cyc(l + 120);
    ctrl_enable = 0;
    wait_cyc(l + 199);
    check("t1_busy_last_cycle", busy, 1);
    wait_cyc(l + 200);
    check("t1_busy_after_wrap", busy, 0);
    check("t1_txnrx_held", txnrx, 1);
    drain(l + 205);

    // armed start, sync at +37, second sync while running ignored
    cfg(99, 0, 40, 50, 90, 0, 1);
    l = cyc + 1;
    ctrl_enable = 1;
    @(negedge clk);
    check("t2_busy_armed", busy, 1);
    check("t2_rx_closed_armed", rx_window, 0);
    s = l + 37;
    push("fs", s + 2);
    push("rxr", s + 2);
    push("rxf", s + 42);
    push("txr", s + 52);
    push("txf", s + 92);
    push_so(s + 2);
    wait_cyc(s);
    check("t2_still_armed", busy, 1);
    sync_in = 1;
    @(negedge clk);
    sync_in = 0;
    check("t2_no_fs_1_after_sync", frame_start, 0);
    wait_cyc(s + 10);
    sync_in = 1;
    @(negedge clk);
    sync_in = 0;
    ctrl_enable = 0;
    wait_cyc(s + 100);
    check("t2_busy_before_wrap", busy, 1);
    wait_cyc(s + 101);
    check("t2_idle_after_wrap", busy, 0);
    drain(s + 105);

    // finite burst of 3 frames with ctrl_enable held high
    cfg(9, 0, 3, 5, 8, 3, 0);
    l = cyc + 1;
    for (int f = 0; f < 3; f++) begin
      push("fs", l + 10 * f + 1);
      push("rxr", l + 10 * f + 1);
      push("rxf", l + 10 * f + 4);
      push("txr", l + 10 * f + 6);
      push("txf", l + 10 * f + 9);
    end
    push_so(l + 1);
    ctrl_enable = 1;
    wait_cyc(l + 29);
    check("t3_busy_frame3", busy, 1);
    wait_cyc(l + 30);
    check("t3_idle_after_burst", busy, 0);
    ctrl_enable = 0;
    drain(l + 35);

    // overlapping windows: error, TX suppressed, then mid-frame reset
    cfg(99, 0, 60, 50, 90, 0, 0);
    l = cyc + 1;
    push("fs", l + 1);
    push("rxr", l + 1);
    push("rxf", l + 31);
    push_so(l + 1);
    ctrl_enable = 1;
    @(negedge clk);
    check("t4_cfg_error_overlap", cfg_error, 1);
    wait_cyc(l + 30);
    check("t4_rx_open", rx_window, 1);
    check("t4_cfg_error_sticky", cfg_error, 1);
    rst = 1;
    ctrl_enable = 0;
    @(negedge clk);
    check("t4_reset_clears_all", outs(), 0);
    rst = 0;
    drain(l + 35);

    // rx_off beyond frame_length+1 flags error
    cfg(9, 0, 11, 0, 0, 0, 0);
    l = cyc + 1;
    push("fs", l + 1);
    push("rxr", l + 1);
    push("rxf", l + 11);
    push_so(l + 1);
    ctrl_enable = 1;
    @(negedge clk);
    ctrl_enable = 0;
    check("t5_cfg_error_range", cfg_error, 1);
    wait_cyc(l + 10);
    check("t5_idle", busy, 0);
    drain(l + 14);

    // frame_length 0: frame_start every cycle, valid config clears the error
    cfg(0, 0, 1, 1, 1, 0, 0);
    check("t6_error_before_latch", cfg_error, 1);
    l = cyc + 1;
    for (int i = 1; i <= 5; i++) push("fs", l + i);
    push("rxr", l + 1);
    push("rxf", l + 6);
    push_so(l + 1);
    ctrl_enable = 1;
    @(negedge clk);
    check("t6_cfg_error_cleared", cfg_error, 0);
    wait_cyc(l + 4);
    ctrl_enable = 0;
    wait_cyc(l + 5);
    check("t6_idle", busy, 0);
    drain(l + 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
